// File: rtl/core_pc_sequencer.sv
// rtl/core_pc_sequencer.sv - next-PC command sequencer with stall, flush and halt control
// Drives the PC's offset/is_branch/is_absolute inputs; holds no PC register itself.
module core_pc_sequencer #(
  parameter int                        MEM_ADDR_WIDTH = 10,
  parameter logic [MEM_ADDR_WIDTH-1:0] TRAP_VECTOR    = '0,
  parameter int                        FLUSH_CYCLES   = 1,
  parameter int                        MC_TIMEOUT     = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MEM_ADDR_WIDTH-1:0] pc_i,
  input  logic [MEM_ADDR_WIDTH-1:0] target_i,
  input  logic                      branch_req_i,
  input  logic                      jump_req_i,
  input  logic                      trap_req_i,
  input  logic                      halt_i,
  input  logic                      resume_i,
  input  logic                      mc_start_i,
  input  logic                      mc_done_i,
  output logic [MEM_ADDR_WIDTH-1:0] offset_o,
  output logic                      is_branch_o,
  output logic                      is_absolute_o,
  output logic                      instr_valid_o,
  output logic                      stall_o,
  output logic                      halted_o,
  output logic                      timeout_o
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [FW-1:0]             FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [WW-1:0]             WD_LAST    = WW'(MC_TIMEOUT - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] SEQ_STEP   = MEM_ADDR_WIDTH'(4);

  typedef enum logic [1:0] {S_RUN, S_MC_WAIT, S_FLUSH, S_HALT} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [FW-1:0] r_flush_cnt;
  logic [WW-1:0] r_wd_cnt;
  logic          r_halted;
  logic          w_wd_expired;

  assign w_wd_expired = (MC_TIMEOUT > 0) && (r_wd_cnt == WD_LAST);
  assign halted_o     = r_halted;

  // Default command is HOLD: an absolute reload of the current PC.
  always_comb begin
    w_next        = r_state;
    offset_o      = pc_i;
    is_branch_o   = 1'b1;
    is_absolute_o = 1'b1;
    instr_valid_o = 1'b0;
    stall_o       = 1'b1;
    timeout_o     = 1'b0;
    case (r_state)
      S_RUN: begin
        instr_valid_o = 1'b1;
        stall_o       = 1'b0;
        if (trap_req_i) begin
          offset_o = TRAP_VECTOR;
          w_next   = S_FLUSH;
        end else if (jump_req_i) begin
          offset_o = target_i;
          w_next   = S_FLUSH;
        end else if (branch_req_i) begin
          offset_o      = target_i;
          is_absolute_o = 1'b0;
          w_next        = S_FLUSH;
        end else if (halt_i) begin
          w_next = S_HALT;
        end else if (mc_start_i && !mc_done_i) begin
          w_next = S_MC_WAIT;
        end else begin
          offset_o      = SEQ_STEP;
          is_branch_o   = 1'b0;
          is_absolute_o = 1'b0;
        end
      end
      S_MC_WAIT: begin
        // A completion arriving on the timeout cycle takes precedence over the trap.
        if (mc_done_i) begin
          offset_o      = SEQ_STEP;
          is_branch_o   = 1'b0;
          is_absolute_o = 1'b0;
          w_next        = S_RUN;
        end else if (w_wd_expired) begin
          offset_o  = TRAP_VECTOR;
          timeout_o = 1'b1;
          w_next    = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt == '0) w_next = S_RUN;
      end
      S_HALT: begin
        if (resume_i) begin
          offset_o      = SEQ_STEP;
          is_branch_o   = 1'b0;
          is_absolute_o = 1'b0;
          w_next        = S_FLUSH;
        end
      end
      default: w_next = S_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_FLUSH;
      r_flush_cnt <= FLUSH_LOAD;
      r_wd_cnt    <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == S_HALT);
      if (w_next == S_FLUSH && r_state != S_FLUSH) r_flush_cnt <= FLUSH_LOAD;
      else if (r_state == S_FLUSH && r_flush_cnt != '0) r_flush_cnt <= r_flush_cnt - FW'(1);
      if (r_state == S_RUN) r_wd_cnt <= '0;
      else if (r_state == S_MC_WAIT) r_wd_cnt <= r_wd_cnt + WW'(1);
    end
  end

endmodule

// File: tb/tb_core_pc_sequencer.sv
// tb/tb_core_pc_sequencer.sv - scoreboard bench for core_pc_sequencer with a PC model
// Each step drives requests, pushes the expected PC/flags, and compares after the edge.
module tb_core_pc_sequencer;

  localparam logic [9:0] TV = 10'h100;

  localparam logic [7:0] RST = 8'h80, TRAP = 8'h40, JUMP = 8'h20, BR = 8'h10;
  localparam logic [7:0] HALT = 8'h08, RES = 8'h04, START = 8'h02, DONE = 8'h01, NONE = 8'h00;
  // Expected flags packed as {instr_valid, stall, halted, timeout}.
  localparam logic [3:0] F_RUN = 4'b1000, F_STL = 4'b0100, F_HLT = 4'b0110, F_TO = 4'b0101;

  typedef struct packed {
    logic [7:0] req;
    logic [9:0] tgt;
    logic [9:0] epc;
    logic [3:0] eflg;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pc_i = '0, target_i = '0;
  logic       branch_req_i = 0, jump_req_i = 0, trap_req_i = 0, halt_i = 0;
  logic       resume_i = 0, mc_start_i = 0, mc_done_i = 0;
  logic [9:0] offset_o;
  logic       is_branch_o, is_absolute_o, instr_valid_o, stall_o, halted_o, timeout_o;

  logic [9:0] s_off;
  logic       s_isb, s_isa, s_valid, s_stall, s_halted, s_to;

  stim_t         stq[$];
  logic [13:0]   sbq[$];
  int            n_vec = 0;
  int            n_err = 0;

  core_pc_sequencer #(
    .MEM_ADDR_WIDTH(10), .TRAP_VECTOR(TV), .FLUSH_CYCLES(1), .MC_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .target_i(target_i),
    .branch_req_i(branch_req_i), .jump_req_i(jump_req_i), .trap_req_i(trap_req_i),
    .halt_i(halt_i), .resume_i(resume_i), .mc_start_i(mc_start_i), .mc_done_i(mc_done_i),
    .offset_o(offset_o), .is_branch_o(is_branch_o), .is_absolute_o(is_absolute_o),
    .instr_valid_o(instr_valid_o), .stall_o(stall_o), .halted_o(halted_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [7:0] req, input logic [9:0] tgt,
                      input logic [9:0] epc, input logic [3:0] eflg);
    stim_t st;
    st.req = req; st.tgt = tgt; st.epc = epc; st.eflg = eflg;
    stq.push_back(st);
  endtask

  task automatic apply(input stim_t st);
    rst_n        = ~st.req[7];
    trap_req_i   = st.req[6];
    jump_req_i   = st.req[5];
    branch_req_i = st.req[4];
    halt_i       = st.req[3];
    resume_i     = st.req[2];
    mc_start_i   = st.req[1];
    mc_done_i    = st.req[0];
    target_i     = st.tgt;
    sbq.push_back({st.epc, st.eflg});
  endtask

  // Samples the Mealy outputs mid-cycle, then advances the PC model on the edge.
  task automatic cycle();
    logic [9:0] nxt;
    @(negedge clk);
    s_off = offset_o; s_isb = is_branch_o; s_isa = is_absolute_o;
    s_valid = instr_valid_o; s_stall = stall_o; s_halted = halted_o; s_to = timeout_o;
    if (!rst_n) nxt = pc_i;
    else if (s_isa) nxt = s_off;
    else nxt = pc_i + s_off;
    @(posedge clk);
    #1;
    pc_i = nxt;
  endtask

  task automatic test_reset();
    int idx = 0;
    logic [13:0] got, e;
    rst_n = 1'b0;
    cycle();
    step(RST, 0, 10'h000, F_STL);
    step(NONE, 0, 10'h000, F_STL);
    step(NONE, 0, 10'h004, F_RUN);
    step(NONE, 0, 10'h008, F_RUN);
    step(NONE, 0, 10'h00C, F_RUN);
    while (stq.size() > 0) begin
      apply(stq.pop_front());
      cycle();
      got = {pc_i, s_valid, s_stall, s_halted, s_to};
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++; $display("FAIL reset[%0d]: no expectation queued", idx);
      end else begin
        e = sbq.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL reset[%0d]: got pc=%h vshT=%b, expected pc=%h vshT=%b",
                   idx, got[13:4], got[3:0], e[13:4], e[3:0]);
        end
      end
      idx++;
    end
  endtask

  task automatic test_priority();
    int idx = 0;
    logic [13:0] got, e;
    step(TRAP | JUMP | BR, 10'h040, TV, F_RUN);
    step(NONE, 0, TV, F_STL);
    step(JUMP, 10'h3FC, 10'h3FC, F_RUN);
    step(NONE, 0, 10'h3FC, F_STL);
    step(BR, 10'h008, 10'h004, F_RUN);
    step(NONE, 0, 10'h004, F_STL);
    step(JUMP, 10'h020, 10'h020, F_RUN);
    step(NONE, 0, 10'h020, F_STL);
    while (stq.size() > 0) begin
      apply(stq.pop_front());
      cycle();
      got = {pc_i, s_valid, s_stall, s_halted, s_to};
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++; $display("FAIL priority[%0d]: no expectation queued", idx);
      end else begin
        e = sbq.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL priority[%0d]: got pc=%h vshT=%b, expected pc=%h vshT=%b",
                   idx, got[13:4], got[3:0], e[13:4], e[3:0]);
        end
      end
      idx++;
    end
  endtask

  task automatic test_multicycle();
    int idx = 0;
    logic [13:0] got, e;
    step(START, 0, 10'h020, F_RUN);
    step(NONE, 0, 10'h020, F_STL);
    step(BR, 10'h080, 10'h020, F_STL);
    step(NONE, 0, 10'h020, F_STL);
    step(NONE, 0, 10'h020, F_STL);
    step(DONE, 0, 10'h024, F_STL);
    step(NONE, 0, 10'h028, F_RUN);
    while (stq.size() > 0) begin
      apply(stq.pop_front());
      cycle();
      got = {pc_i, s_valid, s_stall, s_halted, s_to};
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++; $display("FAIL multicycle[%0d]: no expectation queued", idx);
      end else begin
        e = sbq.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL multicycle[%0d]: got pc=%h vshT=%b, expected pc=%h vshT=%b",
                   idx, got[13:4], got[3:0], e[13:4], e[3:0]);
        end
      end
      idx++;
    end
  endtask

  task automatic test_timeout();
    int idx = 0;
    logic [13:0] got, e;
    step(START, 0, 10'h028, F_RUN);
    for (int i = 0; i < 7; i++) step(NONE, 0, 10'h028, F_STL);
    step(NONE, 0, TV, F_TO);
    step(NONE, 0, TV, F_STL);
    step(START, 0, TV, F_RUN);
    for (int i = 0; i < 7; i++) step(NONE, 0, TV, F_STL);
    step(DONE, 0, TV + 10'd4, F_STL);
    step(NONE, 0, TV + 10'd8, F_RUN);
    while (stq.size() > 0) begin
      apply(stq.pop_front());
      cycle();
      got = {pc_i, s_valid, s_stall, s_halted, s_to};
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++; $display("FAIL timeout[%0d]: no expectation queued", idx);
      end else begin
        e = sbq.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL timeout[%0d]: got pc=%h vshT=%b, expected pc=%h vshT=%b",
                   idx, got[13:4], got[3:0], e[13:4], e[3:0]);
        end
      end
      idx++;
    end
  endtask

  task automatic test_halt();
    int idx = 0;
    logic [13:0] got, e;
    step(JUMP, 10'h010, 10'h010, F_RUN);
    step(NONE, 0, 10'h010, F_STL);
    step(HALT, 0, 10'h010, F_RUN);
    for (int i = 0; i < 10; i++) step(NONE, 0, 10'h010, F_HLT);
    step(RES, 0, 10'h014, F_HLT);
    step(NONE, 0, 10'h014, F_STL);
    step(NONE, 0, 10'h018, F_RUN);
    while (stq.size() > 0) begin
      apply(stq.pop_front());
      cycle();
      got = {pc_i, s_valid, s_stall, s_halted, s_to};
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++; $display("FAIL halt[%0d]: no expectation queued", idx);
      end else begin
        e = sbq.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL halt[%0d]: got pc=%h vshT=%b, expected pc=%h vshT=%b",
                   idx, got[13:4], got[3:0], e[13:4], e[3:0]);
        end
      end
      idx++;
    end
  endtask

  task automatic test_reset_midstream();
    int idx = 0;
    logic [13:0] got, e;
    step(START, 0, 10'h018, F_RUN);
    for (int i = 0; i < 6; i++) step(NONE, 0, 10'h018, F_STL);
    step(RST, 0, 10'h018, F_STL);
    step(NONE, 0, 10'h018, F_STL);
    step(NONE, 0, 10'h01C, F_RUN);
    step(HALT, 0, 10'h01C, F_RUN);
    step(NONE, 0, 10'h01C, F_HLT);
    step(NONE, 0, 10'h01C, F_HLT);
    step(RST, 0, 10'h01C, F_HLT);
    step(NONE, 0, 10'h01C, F_STL);
    for (int i = 1; i <= 9; i++) step(NONE, 0, 10'h01C + 10'(4 * i), F_RUN);
    while (stq.size() > 0) begin
      apply(stq.pop_front());
      cycle();
      got = {pc_i, s_valid, s_stall, s_halted, s_to};
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++; $display("FAIL reset_mid[%0d]: no expectation queued", idx);
      end else begin
        e = sbq.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL reset_mid[%0d]: got pc=%h vshT=%b, expected pc=%h vshT=%b",
                   idx, got[13:4], got[3:0], e[13:4], e[3:0]);
        end
      end
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_multicycle();
    test_timeout();
    test_halt();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule

// File: doc/core_pc_sequencer.md
# core_pc_sequencer

Next-PC controller for the core's program counter. Each cycle it drives the program counter's `offset_i`, `is_branch_i` and `is_absolute_i` inputs to select one of: advance by 4, relative branch, absolute jump, trap vector, or hold. It stalls fetch while a multi-cycle M/F unit is busy and inserts flush bubbles after redirects. It sits between decode/execute and the program counter and has no PC register of its own. A hold is encoded as an absolute load of the current PC.

## Interface
- `MEM_ADDR_WIDTH`, 10, PC/address width
- `TRAP_VECTOR`, 0, absolute trap target; must fit in MEM_ADDR_WIDTH bits
- `FLUSH_CYCLES`, 1, invalid-fetch bubbles after any redirect or reset; ≥1
- `MC_TIMEOUT`, 64, max MC_WAIT cycles before a timeout trap; 0 disables the watchdog

- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `pc_i`  in  MEM_ADDR_WIDTH  current program counter value
- `target_i`  in  MEM_ADDR_WIDTH  branch offset (relative) or jump target (absolute)
- `branch_req_i`  in  1  taken relative branch
- `jump_req_i`  in  1  absolute jump
- `trap_req_i`  in  1  exception or ecall
- `halt_i`  in  1  ebreak; halt fetch
- `resume_i`  in  1  leave HALT
- `mc_start_i`  in  1  current instruction is a multi-cycle M/F op
- `mc_done_i`  in  1  multi-cycle unit result ready
- `offset_o`  out  MEM_ADDR_WIDTH  to PC `offset_i`
- `is_branch_o`  out  1  to PC `is_branch_i`
- `is_absolute_o`  out  1  to PC `is_absolute_i`
- `instr_valid_o`  out  1  fetched instruction is valid for decode
- `stall_o`  out  1  hold decode/execute
- `halted_o`  out  1  registered; high while in HALT
- `timeout_o`  out  1  one-cycle pulse when the watchdog trap is issued

## Operation
- Command encodings (`offset_o` / `is_branch_o` / `is_absolute_o`):
  - SEQ: 4 / 0 / 0
  - BR: `target_i` / 1 / 0
  - ABS(x): x / 1 / 1
  - HOLD: ABS(`pc_i`)
- All command outputs are combinational (Mealy) from the current state and inputs. The PC registers them at the next edge.
- FSM states: RUN, MC_WAIT, FLUSH, HALT.
- RUN: `instr_valid_o`=1, `stall_o`=0. Requests are resolved in this priority order:
  1. `trap_req_i` → ABS(TRAP_VECTOR), next FLUSH.
  2. `jump_req_i` → ABS(`target_i`), next FLUSH.
  3. `branch_req_i` → BR, next FLUSH.
  4. `halt_i` → HOLD, next HALT.
  5. `mc_start_i` with `mc_done_i`=1 → SEQ, stay in RUN (single-cycle completion).
  6. `mc_start_i` with `mc_done_i`=0 → HOLD, next MC_WAIT, watchdog counter cleared.
  7. Otherwise → SEQ, stay in RUN.
- MC_WAIT: `instr_valid_o`=0, `stall_o`=1. Branch, jump, trap, halt and start inputs are all ignored.
  - `mc_done_i` → SEQ, next RUN.
  - Otherwise the counter increments. When the counter reaches MC_TIMEOUT-1 without `mc_done_i`: ABS(TRAP_VECTOR), `timeout_o`=1, next FLUSH.
  - `mc_done_i` in the same cycle as the timeout condition: done wins, no trap.
- FLUSH: HOLD, `instr_valid_o`=0, `stall_o`=1.
  - Bubble counter loads FLUSH_CYCLES-1 on entry and decrements each cycle.
  - Transition to RUN occurs in the cycle the counter reads 0.
  - All request inputs are ignored.
- HALT: HOLD, `instr_valid_o`=0, `stall_o`=1, `halted_o`=1.
  - `resume_i` → SEQ (step past the ebreak), next FLUSH.
- The `pc_i`+4 and `pc_i`+offset arithmetic is performed by the PC, modulo 2^MEM_ADDR_WIDTH. Wrap-around is legal and not flagged.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State → FLUSH with counter = FLUSH_CYCLES-1; watchdog counter = 0.
  - Registered outputs: `halted_o`=0.
  - Resulting combinational outputs: HOLD, `instr_valid_o`=0, `stall_o`=1, `timeout_o`=0.
- A reset asserted mid-MC_WAIT, mid-FLUSH or in HALT discards all state. No trap or timeout is generated.
- Redirect latency: request in cycle N → PC holds the target after edge N+1. `instr_valid_o` stays 0 for FLUSH_CYCLES cycles, then returns to 1.
- Multi-cycle op: PC is frozen from the `mc_start_i` cycle until the cycle `mc_done_i` is seen. It advances by 4 on the edge following `mc_done_i`.
- Timeout: with `mc_done_i` never asserted, the trap command is issued in the MC_TIMEOUT-th cycle spent in MC_WAIT.
- `halted_o` rises one edge after `halt_i` is accepted and falls one edge after `resume_i`.

## Test plan
- Reset, FLUSH_CYCLES=1, `pc_i`=0, no requests → one cycle of `instr_valid_o`=0, then SEQ each cycle; the PC model counts 0, 4, 8, 12.
- RUN with `branch_req_i`, `jump_req_i` and `trap_req_i` all high in one cycle, `target_i`=0x40 → ABS(TRAP_VECTOR), then FLUSH. Repeat with branch only at `pc_i`=0x3FC, `target_i`=8 → PC wraps to 0x004.
- `mc_start_i` at `pc_i`=0x20, `mc_done_i` asserted 5 cycles later → PC stays 0x20 for 5 cycles with `stall_o`=1, then 0x24. A `branch_req_i` pulse during the wait has no effect.
- MC_TIMEOUT=8, `mc_start_i` with no done → `timeout_o` pulses in the 8th MC_WAIT cycle and the PC becomes TRAP_VECTOR. Same scenario with `mc_done_i` in that cycle → no trap, PC advances by 4.
- `halt_i` at `pc_i`=0x10 → `halted_o`=1 and PC held for 10 cycles. `resume_i` → PC=0x14, one bubble, then RUN.
- `rst_n` pulsed low mid-MC_WAIT and mid-HALT → next cycle in FLUSH, `halted_o`=0, no `timeout_o`.
